axi_sim_top: RTL and testbench
==============================

# axi_sim_top

Self-contained AXI4 simulation subsystem: an active master traffic generator drives a passive pass-through monitor/scoreboard, which forwards every channel unchanged to an AXI4 slave memory model. After reset, the master writes a deterministic data pattern into memory with INCR bursts, reads it back, and the monitor checks every read beat and response. The block sits at the top of the AXI verification environment. It needs only clock and reset, and reports its result on status outputs.

## Interface
- ADDR_W, 12: byte-address width of the internal AXI bus.
- DATA_W, 32: data width; fixed at 32 (4-byte beats, WSTRB all ones).
- MEM_DEPTH, 256: number of 32-bit words in the slave memory; power of two.
- NUM_TXN, 16: number of write bursts, followed by the same number of read bursts.
- BURST_LEN, 4: beats per burst (AWLEN/ARLEN = BURST_LEN-1), 1..16.
- INJECT_ERR, 0: when 1, the slave inverts bit 0 of read data for word address 5.

Ports:
- aclk, in, 1: single clock; everything is rising-edge.
- aresetn, in, 1: reset; asynchronous and active-low.
- done, out, 1: all read bursts completed.
- pass, out, 1: done && err_count==0.
- err_count, out, 8: saturating count of monitor errors.
- beat_count, out, 16: count of completed W and R data handshakes.

## Operation
- Word index k = (byte address >> 2) mod MEM_DEPTH. Write data for index k = 32'hA500_0000 | k.
- Transaction i (0..NUM_TXN-1) starts at byte address i*BURST_LEN*4, truncated to ADDR_W. Every burst is INCR with size 4 bytes, and IDs are 0.
- Master FSM: IDLE -> WR_ADDR -> WR_DATA -> WR_RESP, repeated NUM_TXN times. It then runs RD_ADDR -> RD_DATA, repeated NUM_TXN times. Then DONE, which it holds until reset.
- The master issues one transaction at a time with no outstanding overlap. BREADY and RREADY are held at 1.
- Slave write FSM: W_IDLE (AWREADY=1) -> W_DATA (WREADY=1; store one word per beat) -> W_RESP (BVALID=1, BRESP=OKAY). It leaves W_DATA on the handshake with WLAST.
- Slave read FSM: R_IDLE (ARREADY=1) -> R_DATA (RVALID=1; one beat per cycle; RLAST on the final beat; RRESP=OKAY).
- Memory address wraps modulo MEM_DEPTH. Aliased writes store identical values, so wrap is not an error.
- Memory contents are not cleared by reset.
- The monitor passes signals through combinationally and adds 1 to err_count (saturating at 255) for each of these:
  - an R beat whose data ≠ the pattern for its index;
  - BRESP or RRESP ≠ OKAY;
  - WLAST or RLAST asserted on the wrong beat, or missing on the last beat.

## Timing
- Reset (asynchronous, active-low) clears all FSMs to IDLE, all VALIDs to 0, and done, pass, err_count and beat_count to 0.
- Asserting reset mid-burst aborts the burst immediately. The sequence restarts from transaction 0 after release.
- VALID stays asserted, with stable payload, until its handshake.
- The first AWVALID is asserted on the first rising edge after aresetn deasserts; that is cycle 0.
- Write burst (relative to its AW handshake at cycle c):
  - W beats at c+1..c+BURST_LEN;
  - B handshake at c+BURST_LEN+1;
  - next AW at c+BURST_LEN+2.
- The first AR follows the last B one cycle later, with the same spacing as the AW-to-AW gap.
- Read burst (relative to its AR handshake at cycle c):
  - R beats at c+1..c+BURST_LEN;
  - next AR at c+BURST_LEN+1.
- Defaults: 16×6 + 16×5 = 176 handshake cycles. done and pass register high on the edge after the final RLAST handshake and stay high until reset.
- err_count and beat_count update on the edge after the triggering handshake.

## Test plan
- Defaults, reset released at t0 → done=1 at cycle 176 after the first AW; pass=1; err_count=0; beat_count=128.
- Defaults, sample the R beat for word 5 → RDATA=32'hA500_0005 with RLAST only on beats 3, 7, 11, …
- INJECT_ERR=1 → done=1, err_count=1, pass=0.
- NUM_TXN=80, BURST_LEN=4 (320 words > MEM_DEPTH) → address wraps; pass=1; beat_count=640.
- Pulse aresetn low during the 3rd write burst → all outputs go to 0 immediately. After release, the full sequence reruns and pass=1 at 176 cycles.
- BURST_LEN=1, NUM_TXN=2 → AWLEN=0 and WLAST on every beat; done after 2×3 + 2×2 = 10 cycles; pass=1.

Source files
------------

// File: rtl/axi_sim_top.sv
// rtl/axi_sim_top.sv - AXI4 self-test loop: pattern master, pass-through monitor, slave memory model
module axi_sim_top #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int NUM_TXN    = 16,
    parameter int BURST_LEN  = 4,
    parameter int INJECT_ERR = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] beat_count
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int TXN_W = $clog2(NUM_TXN) + 1;
    localparam logic [7:0] LEN = 8'(BURST_LEN - 1);
    localparam logic [TXN_W-1:0] LAST_TXN = TXN_W'(NUM_TXN - 1);

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> 2);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [IDX_W-1:0] k);
        return DATA_W'(32'hA500_0000) | DATA_W'(k);
    endfunction

    logic              awvalid, awready, arvalid, arready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic              wvalid, wready, wlast, bvalid, bready;
    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] wdata, rdata;
    logic [1:0]        bresp, rresp;

    // ---------------- master ----------------
    typedef enum logic [2:0] {
        M_IDLE, M_WR_ADDR, M_WR_DATA, M_WR_RESP, M_RD_ADDR, M_RD_DATA, M_DONE
    } m_state_e;

    m_state_e          m_state_q, m_state_d;
    logic [TXN_W-1:0]  txn_q, txn_d;
    logic [7:0]        mbeat_q, mbeat_d;
    logic [ADDR_W-1:0] burst_addr;

    assign burst_addr = ADDR_W'(txn_q * (BURST_LEN * 4));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_state_q <= M_IDLE;
            txn_q     <= '0;
            mbeat_q   <= '0;
        end else begin
            m_state_q <= m_state_d;
            txn_q     <= txn_d;
            mbeat_q   <= mbeat_d;
        end
    end

    always_comb begin
        m_state_d = m_state_q;
        txn_d     = txn_q;
        mbeat_d   = mbeat_q;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        arvalid   = 1'b0;
        bready    = 1'b1;
        rready    = 1'b1;
        awaddr    = burst_addr;
        araddr    = burst_addr;
        awlen     = LEN;
        arlen     = LEN;
        wdata     = pattern(word_idx(burst_addr) + IDX_W'(mbeat_q));
        case (m_state_q)
            M_IDLE: m_state_d = M_WR_ADDR;
            M_WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    m_state_d = M_WR_DATA;
                    mbeat_d   = '0;
                end
            end
            M_WR_DATA: begin
                wvalid = 1'b1;
                wlast  = (mbeat_q == LEN);
                if (wready) begin
                    mbeat_d = mbeat_q + 8'd1;
                    if (wlast) m_state_d = M_WR_RESP;
                end
            end
            M_WR_RESP: begin
                if (bvalid) begin
                    if (txn_q == LAST_TXN) begin
                        m_state_d = M_RD_ADDR;
                        txn_d     = '0;
                    end else begin
                        m_state_d = M_WR_ADDR;
                        txn_d     = txn_q + 1'b1;
                    end
                end
            end
            M_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) m_state_d = M_RD_DATA;
            end
            M_RD_DATA: begin
                if (rvalid && rlast) begin
                    if (txn_q == LAST_TXN) begin
                        m_state_d = M_DONE;
                    end else begin
                        m_state_d = M_RD_ADDR;
                        txn_d     = txn_q + 1'b1;
                    end
                end
            end
            M_DONE: m_state_d = M_DONE;
            default: m_state_d = M_IDLE;
        endcase
    end

    // ---------------- slave memory ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} sw_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         sr_state_e;

    sw_state_e         sw_q, sw_d;
    sr_state_e         sr_q, sr_d;
    logic [IDX_W-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
    logic [7:0]        rcnt_q, rcnt_d, rlen_q, rlen_d;
    logic              mem_we, flip;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sw_q    <= W_IDLE;
            sr_q    <= R_IDLE;
            waddr_q <= '0;
            raddr_q <= '0;
            rcnt_q  <= '0;
            rlen_q  <= '0;
        end else begin
            sw_q    <= sw_d;
            sr_q    <= sr_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            rcnt_q  <= rcnt_d;
            rlen_q  <= rlen_d;
        end
    end

    // Contents deliberately survive reset; a rerun rewrites every location it reads.
    always_ff @(posedge aclk) begin
        if (mem_we) mem[waddr_q] <= wdata;
    end

    assign flip  = (INJECT_ERR != 0) && (raddr_q == IDX_W'(5));
    assign rdata = mem[raddr_q] ^ {{(DATA_W-1){1'b0}}, flip};
    assign rresp = 2'b00;
    assign bresp = 2'b00;

    always_comb begin
        sw_d    = sw_q;
        waddr_d = waddr_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        mem_we  = 1'b0;
        case (sw_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    sw_d    = W_DATA;
                    waddr_d = word_idx(awaddr);
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we  = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                    if (wlast) sw_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) sw_d = W_IDLE;
            end
            default: sw_d = W_IDLE;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        raddr_d = raddr_q;
        rcnt_d  = rcnt_q;
        rlen_d  = rlen_q;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (sr_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    sr_d    = R_DATA;
                    raddr_d = word_idx(araddr);
                    rlen_d  = arlen;
                    rcnt_d  = '0;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (rcnt_q == rlen_q);
                if (rready) begin
                    raddr_d = raddr_q + 1'b1;
                    rcnt_d  = rcnt_q + 8'd1;
                    if (rlast) sr_d = R_IDLE;
                end
            end
            default: sr_d = R_IDLE;
        endcase
    end

    // ---------------- monitor ----------------
    logic [7:0]       mw_cnt_q, mw_cnt_d, mw_len_q, mw_len_d;
    logic [7:0]       mr_cnt_q, mr_cnt_d, mr_len_q, mr_len_d;
    logic [IDX_W-1:0] mr_idx_q, mr_idx_d;
    logic [7:0]       err_q, err_d;
    logic [15:0]      beats_q, beats_d;
    logic [2:0]       err_n;
    logic [8:0]       err_sum;
    logic             w_hs, r_hs;

    assign w_hs = wvalid && wready;
    assign r_hs = rvalid && rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mw_cnt_q <= '0;
            mw_len_q <= '0;
            mr_cnt_q <= '0;
            mr_len_q <= '0;
            mr_idx_q <= '0;
            err_q    <= '0;
            beats_q  <= '0;
        end else begin
            mw_cnt_q <= mw_cnt_d;
            mw_len_q <= mw_len_d;
            mr_cnt_q <= mr_cnt_d;
            mr_len_q <= mr_len_d;
            mr_idx_q <= mr_idx_d;
            err_q    <= err_d;
            beats_q  <= beats_d;
        end
    end

    always_comb begin
        mw_cnt_d = mw_cnt_q;
        mw_len_d = mw_len_q;
        mr_cnt_d = mr_cnt_q;
        mr_len_d = mr_len_q;
        mr_idx_d = mr_idx_q;
        err_n    = '0;
        if (awvalid && awready) begin
            mw_cnt_d = '0;
            mw_len_d = awlen;
        end else if (w_hs) begin
            mw_cnt_d = mw_cnt_q + 8'd1;
            if (wlast != (mw_cnt_q == mw_len_q)) err_n = err_n + 3'd1;
        end
        if (bvalid && bready && bresp != 2'b00) err_n = err_n + 3'd1;
        if (arvalid && arready) begin
            mr_cnt_d = '0;
            mr_len_d = arlen;
            mr_idx_d = word_idx(araddr);
        end else if (r_hs) begin
            mr_cnt_d = mr_cnt_q + 8'd1;
            mr_idx_d = mr_idx_q + 1'b1;
            if (rdata != pattern(mr_idx_q))          err_n = err_n + 3'd1;
            if (rresp != 2'b00)                      err_n = err_n + 3'd1;
            if (rlast != (mr_cnt_q == mr_len_q))     err_n = err_n + 3'd1;
        end
        err_sum = {1'b0, err_q} + {6'd0, err_n};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
        beats_d = beats_q + {15'd0, w_hs} + {15'd0, r_hs};
    end

    assign done       = (m_state_q == M_DONE);
    assign pass       = done && (err_q == 8'd0);
    assign err_count  = err_q;
    assign beat_count = beats_q;
endmodule

// File: tb/tb_axi_sim_top.sv
// tb/tb_axi_sim_top.sv - bench for axi_sim_top against a cycle-indexed transaction model
module tb_axi_sim_top;
    localparam int BL = 4, NT = 16, WP = BL + 2, RP = BL + 1;
    localparam int WT = NT * WP, TOT = WT + NT * RP;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        done0, pass0, done1, pass1, done2, pass2, done3, pass3;
    logic [7:0]  err0, err1, err2, err3;
    logic [15:0] beat0, beat1, beat2, beat3;
    int total = 0, passed = 0, failed = 0;

    axi_sim_top d0 (.aclk(clk), .aresetn(rst_n), .done(done0), .pass(pass0), .err_count(err0), .beat_count(beat0));
    axi_sim_top #(.INJECT_ERR(1)) d1 (.aclk(clk), .aresetn(rst_n), .done(done1), .pass(pass1), .err_count(err1), .beat_count(beat1));
    axi_sim_top #(.NUM_TXN(80)) d2 (.aclk(clk), .aresetn(rst_n), .done(done2), .pass(pass2), .err_count(err2), .beat_count(beat2));
    axi_sim_top #(.NUM_TXN(2), .BURST_LEN(1)) d3 (.aclk(clk), .aresetn(rst_n), .done(done3), .pass(pass3), .err_count(err3), .beat_count(beat3));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'hA500_0000 | 32'(k);
    endfunction

    // Expected bus/status view of d0 during cycle n, given beats completed before n.
    function automatic logic [107:0] model(input int n, input int beats);
        logic aw = 0, w = 0, b = 0, ar = 0, r = 0, rl = 0;
        logic [11:0] a = '0;
        logic [31:0] wd = '0, rd = '0;
        int t, p, base;
        if (n < WT) begin
            t = n / WP; p = n % WP; base = (t * BL * 4) % 4096;
            if (p == 0) begin aw = 1; a = 12'(base); end
            else if (p <= BL) begin w = 1; wd = pat(((base >> 2) + p - 1) % 256); end
            else b = 1;
        end else if (n < TOT) begin
            t = (n - WT) / RP; p = (n - WT) % RP; base = (t * BL * 4) % 4096;
            if (p == 0) begin ar = 1; a = 12'(base); end
            else begin r = 1; rd = pat(((base >> 2) + p - 1) % 256); rl = (p == BL); end
        end
        return {aw, w, b, ar, r, a, wd, rd, rl, n >= TOT, n >= TOT, 8'd0, 16'(beats)};
    endfunction

    function automatic logic [107:0] observe();
        logic [11:0] a;
        a = d0.awvalid ? d0.awaddr : (d0.arvalid ? d0.araddr : 12'd0);
        return {d0.awvalid, d0.wvalid, d0.bvalid, d0.arvalid, d0.rvalid, a,
                d0.wvalid ? d0.wdata : 32'd0, d0.rvalid ? d0.rdata : 32'd0,
                d0.rvalid & d0.rlast, done0, pass0, err0, beat0};
    endfunction

    // Assumes reset was just released on a falling edge; checks cycles 0..last_n.
    task automatic run(input int last_n);
        int beats = 0;
        for (int n = 0; n <= last_n; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n <= TOT + 4) chk($sformatf("d0_cycle%0d", n), 128'(observe()), 128'(model(n, beats)));
            if ((n < WT && n % WP >= 1 && n % WP <= BL) || (n >= WT && n < TOT && (n - WT) % RP != 0))
                beats++;
            if (n == 103) chk("d0_rdata_word5", 128'({d0.rvalid, d0.rdata}), 128'({1'b1, 32'hA500_0005}));
            if (n == 0) chk("d3_awlen0", 128'({d3.awvalid, d3.awlen}), 128'({1'b1, 8'h00}));
            if (n == 1 || n == 4) chk("d3_wlast", 128'({d3.wvalid, d3.wlast}), 128'(2'b11));
            if (n == 9) chk("d3_not_done", 128'({done3, pass3}), 128'(2'b00));
            if (n == 10) chk("d3_done", 128'({done3, pass3, err3, beat3}), 128'({2'b11, 8'd0, 16'd4}));
            if (n == TOT - 1) chk("d1_not_done", 128'(done1), 128'(1'b0));
            if (n == TOT) chk("d1_done", 128'({done1, pass1, err1, beat1}), 128'({2'b10, 8'd1, 16'd128}));
            if (n == 879) chk("d2_not_done", 128'(done2), 128'(1'b0));
            if (n == 880) chk("d2_done", 128'({done2, pass2, err2, beat2}), 128'({2'b11, 8'd0, 16'd640}));
        end
    endtask

    initial begin
        int r, hold;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        chk("reset_state", 128'(observe()), 128'(0));
        rst_n = 1'b1;
        run(882);

        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
        r = $urandom_range(2 * WP + 1, 3 * WP - 1);
        run(r);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_mid_burst", 128'({observe(), done3, err3, beat3}), 128'(0));
        hold = $urandom_range(1, 3);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        run(882);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
